// File: rtl/top_con_rx_tx_loopback.sv
// UART loopback system: PC-side TX -> FPGA RX -> operand collector/ALU -> FPGA TX -> PC-side RX.
// All four UART engines share one 16x oversampling tick.

module uart_baud_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Down-counter: reload on terminal count, one tick every DIV cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= CNT_W'(DIV - 1);
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// state    | meaning
// TX_IDLE  | line high, ready for a byte
// TX_START | start bit, 16 ticks low
// TX_DATA  | data bits LSB first, 16 ticks each
// TX_STOP  | stop bit, 16 ticks high
module uart_tx #(
  parameter int NB_DATA = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [NB_DATA-1:0] data,
  output logic               ready,
  output logic               tx
);
  localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t          state;
  logic [3:0]         tick_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [NB_DATA-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      ready    <= 1'b1;
      tx       <= 1'b1;
      tick_cnt <= 4'd15;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start && ready) begin
            shreg    <= data;
            state    <= TX_START;
            ready    <= 1'b0;
            tx       <= 1'b0;
            tick_cnt <= 4'd15;
          end
        end
        TX_START: begin
          if (tick) begin
            if (tick_cnt == 4'd0) begin
              state    <= TX_DATA;
              tick_cnt <= 4'd15;
              bit_idx  <= '0;
              tx       <= shreg[0];
            end else begin
              tick_cnt <= tick_cnt - 4'd1;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (tick_cnt == 4'd0) begin
              tick_cnt <= 4'd15;
              shreg    <= shreg >> 1;
              if (bit_idx == IDX_W'(NB_DATA - 1)) begin
                state <= TX_STOP;
                tx    <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 1'b1;
                tx      <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt - 4'd1;
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (tick_cnt == 4'd0) begin
              state <= TX_IDLE;
              ready <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt - 4'd1;
            end
          end
        end
        default: begin
          state <= TX_IDLE;
          ready <= 1'b1;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// state    | meaning
// RX_IDLE  | waiting for a falling edge on the line
// RX_START | 8 ticks to mid start bit, then confirm low
// RX_DATA  | sample each data bit every 16 ticks
// RX_STOP  | 16 ticks into stop bit, then done pulse
module uart_rx #(
  parameter int NB_DATA = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               rx,
  output logic [NB_DATA-1:0] data,
  output logic               done
);
  localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t          state;
  logic               rx_meta;
  logic               rx_sync;
  logic [3:0]         tick_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [NB_DATA-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RX_IDLE;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      tick_cnt <= 4'd7;
      bit_idx  <= '0;
      shreg    <= '0;
      data     <= '0;
      done     <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      done    <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_sync) begin
            state    <= RX_START;
            tick_cnt <= 4'd7;
          end
        end
        RX_START: begin
          if (tick) begin
            if (tick_cnt == 4'd0) begin
              // A glitch that is gone by mid start bit is not a frame
              if (!rx_sync) begin
                state    <= RX_DATA;
                tick_cnt <= 4'd15;
                bit_idx  <= '0;
              end else begin
                state <= RX_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt - 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (tick_cnt == 4'd0) begin
              shreg    <= {rx_sync, shreg[NB_DATA-1:1]};
              tick_cnt <= 4'd15;
              if (bit_idx == IDX_W'(NB_DATA - 1)) begin
                state <= RX_STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt - 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (tick_cnt == 4'd0) begin
              state <= RX_IDLE;
              done  <= 1'b1;
              data  <= shreg;
            end else begin
              tick_cnt <= tick_cnt - 4'd1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// Opcodes follow MIPS funct codes; anything unknown yields zero.
module alu #(
  parameter int NB_DATA = 8
) (
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  input  logic [NB_DATA-1:0] op,
  output logic [NB_DATA-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      NB_DATA'(8'h20): result = a + b;
      NB_DATA'(8'h22): result = a - b;
      NB_DATA'(8'h24): result = a & b;
      NB_DATA'(8'h25): result = a | b;
      NB_DATA'(8'h26): result = a ^ b;
      NB_DATA'(8'h27): result = ~(a | b);
      NB_DATA'(8'h03): result = NB_DATA'($signed(a) >>> b);
      NB_DATA'(8'h02): result = a >> b;
      default:         result = '0;
    endcase
  end
endmodule

// state   | meaning
// WAIT_A  | next received byte is operand A
// WAIT_B  | next received byte is operand B
// WAIT_OP | next received byte is the opcode
// SEND    | hand ALU result to the TX once it is idle
module operand_collector #(
  parameter int NB_DATA = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic               rx_done,
  input  logic               tx_ready,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data
);
  typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_OP, SEND} col_state_t;

  col_state_t         state;
  logic [NB_DATA-1:0] op_a;
  logic [NB_DATA-1:0] op_b;
  logic [NB_DATA-1:0] opcode;
  logic [NB_DATA-1:0] alu_result;

  alu #(.NB_DATA(NB_DATA)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (opcode),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_A;
      op_a     <= '0;
      op_b     <= '0;
      opcode   <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        WAIT_A: begin
          if (rx_done) begin
            op_a  <= rx_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_done) begin
            op_b  <= rx_data;
            state <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (rx_done) begin
            opcode <= rx_data;
            state  <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_data  <= alu_result;
            state    <= WAIT_A;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end
endmodule

module top_con_rx_tx_loopback #(
  parameter int F_CLOCK = 100_000_000,
  parameter int BAUD    = 9600,
  parameter int NB_DATA = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_pc_tx_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid
);
  localparam int DIV = F_CLOCK / (BAUD * 16);

  logic               tick;
  logic               line_pc2fpga;
  logic               line_fpga2pc;
  logic [NB_DATA-1:0] fpga_rx_data;
  logic               fpga_rx_done;
  logic               fpga_tx_ready;
  logic               fpga_tx_start;
  logic [NB_DATA-1:0] fpga_tx_data;
  logic [NB_DATA-1:0] pc_rx_data;
  logic               pc_rx_done;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk   (i_clk),
    .reset (i_reset),
    .tick  (tick)
  );

  uart_tx #(.NB_DATA(NB_DATA)) u_pc_tx (
    .clk   (i_clk),
    .reset (i_reset),
    .tick  (tick),
    .start (i_valid),
    .data  (i_data),
    .ready (o_pc_tx_ready),
    .tx    (line_pc2fpga)
  );

  uart_rx #(.NB_DATA(NB_DATA)) u_fpga_rx (
    .clk   (i_clk),
    .reset (i_reset),
    .tick  (tick),
    .rx    (line_pc2fpga),
    .data  (fpga_rx_data),
    .done  (fpga_rx_done)
  );

  operand_collector #(.NB_DATA(NB_DATA)) u_collector (
    .clk      (i_clk),
    .reset    (i_reset),
    .rx_data  (fpga_rx_data),
    .rx_done  (fpga_rx_done),
    .tx_ready (fpga_tx_ready),
    .tx_start (fpga_tx_start),
    .tx_data  (fpga_tx_data)
  );

  uart_tx #(.NB_DATA(NB_DATA)) u_fpga_tx (
    .clk   (i_clk),
    .reset (i_reset),
    .tick  (tick),
    .start (fpga_tx_start),
    .data  (fpga_tx_data),
    .ready (fpga_tx_ready),
    .tx    (line_fpga2pc)
  );

  uart_rx #(.NB_DATA(NB_DATA)) u_pc_rx (
    .clk   (i_clk),
    .reset (i_reset),
    .tick  (tick),
    .rx    (line_fpga2pc),
    .data  (pc_rx_data),
    .done  (pc_rx_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= pc_rx_done;
      if (pc_rx_done) begin
        o_data <= pc_rx_data;
      end
    end
  end
endmodule

// File: tb/tb_top_con_rx_tx_loopback.sv
// Scoreboard bench for the UART loopback: expected results queued at stimulus time,
// popped and compared by an independent monitor on every o_valid pulse.

module tb_top_con_rx_tx_loopback;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic [7:0] out_data;
  logic       out_valid;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // 64 / (1*16) = 4 cycles per tick, 640 cycles per frame
  top_con_rx_tx_loopback #(.F_CLOCK(64), .BAUD(1), .NB_DATA(8)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_data        (data),
    .i_valid       (valid),
    .o_pc_tx_ready (ready),
    .o_data        (out_data),
    .o_valid       (out_valid)
  );

  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL valid_in_reset got=%b want=0", out_valid);
      end
    end else if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got=%h want=none", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL result got=%h want=%h", out_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 5000);
    if (ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=%b want=1", ready);
    end
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] want);
    send_byte(a);
    send_byte(b);
    exp_q.push_back(want);
    send_byte(op);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d_pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_data", out_data, 8'h00);
    check("reset_valid", {7'b0, out_valid}, 8'h00);
    check("reset_ready", {7'b0, ready}, 8'h01);

    send_op(8'h43, 8'h21, 8'h20, 8'h64);
    wait_drain();
    send_op(8'h21, 8'h43, 8'h22, 8'hDE);
    wait_drain();
    send_op(8'h80, 8'h02, 8'h03, 8'hE0);
    wait_drain();
    send_op(8'h80, 8'h02, 8'h02, 8'h20);
    wait_drain();
    send_op(8'hF0, 8'h0F, 8'h3F, 8'h00);
    wait_drain();
    send_op(8'hF0, 8'h3C, 8'h24, 8'h30);
    send_op(8'h50, 8'h0A, 8'h25, 8'h5A);
    send_op(8'h50, 8'h0A, 8'h27, 8'hA5);
    wait_drain();
    send_op(8'h80, 8'h09, 8'h03, 8'hFF);
    send_op(8'hFF, 8'h08, 8'h02, 8'h00);
    send_op(8'hFF, 8'h02, 8'h20, 8'h01);
    wait_drain();

    // Byte offered while PC TX is busy must be dropped
    send_byte(8'h0F);
    repeat (50) @(negedge clk);
    check("busy_ready", {7'b0, ready}, 8'h00);
    data  = 8'hFF;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    send_byte(8'h3C);
    exp_q.push_back(8'h33);
    send_byte(8'h26);
    wait_drain();

    // Reset mid-frame after A and B: operands discarded, no result
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (300) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_data", out_data, 8'h00);
    check("post_reset_ready", {7'b0, ready}, 8'h01);
    send_op(8'h01, 8'h01, 8'h20, 8'h02);
    wait_drain();

    repeat (1500) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
